// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: interrupt merger and periodic reload timer for the MMU09 SBC.
// Combines the UART IRQ, the CH375 IRQ and an internal tick timer into a single
// masked, registered, active-low irq_n for the 6809 /IRQ input.
//
// Register map (i_addr):
//   0 STATUS  rd {4'b0, TOVR, CH375, UART, TPEND}; wr b0=1 clears TPEND and TOVR
//   1 MASK    rd/wr b2:0 = {CH375 enable, UART enable, timer enable}
//   2 RELLO   wr stages the low reload byte; rd committed reload[7:0]
//   3 RELHI   wr commits {data, staged low}, loads counter, clears prescaler
//
// Build option: define IRQ_SYNC_EN to pass i_uartirq/i_chirq through two-flop
// synchronisers (reset to the inactive level) before STATUS and irq_n.
// Without it the external lines are used directly.
module irq_timer_ctrl #(
    parameter int PRESCALE = 1000
) (
    input  logic       i_eclk,
    input  logic       i_reset,
    input  logic       i_cs_n,
    input  logic       i_rw,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    input  logic       i_uartirq,
    input  logic       i_chirq,
    output logic       irq_n
);

    localparam logic [1:0]  ADDR_STATUS = 2'd0;
    localparam logic [1:0]  ADDR_MASK   = 2'd1;
    localparam logic [1:0]  ADDR_RELLO  = 2'd2;
    localparam logic [1:0]  ADDR_RELHI  = 2'd3;
    localparam logic [15:0] PS_LAST     = 16'(PRESCALE - 1);

    // Programmer-visible and timer state
    logic [2:0]  r_mask;
    logic [15:0] r_reload;
    logic [7:0]  r_rel_lo_stage;
    logic [15:0] r_count;
    logic [15:0] r_presc;
    logic        r_tpend;
    logic        r_tovr;
    logic        r_irq_n;

    // Bus decode
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_status;
    logic        w_wr_mask;
    logic        w_wr_rello;
    logic        w_wr_relhi;
    logic        w_clr;

    // External interrupt levels (active high after conditioning)
    logic        w_uart_n;
    logic        w_ch_n;
    logic        w_uart;
    logic        w_ch;

    // Next-state values
    logic [15:0] w_presc_next;
    logic [15:0] w_count_next;
    logic        w_expire;
    logic        w_tpend_next;
    logic        w_tovr_next;
    logic [2:0]  w_mask_next;
    logic        w_irq_n_next;
    logic [7:0]  w_rd_data;

    assign w_wr        = ~i_cs_n & ~i_rw;
    assign w_rd        = ~i_cs_n &  i_rw;
    assign w_wr_status = w_wr & (i_addr == ADDR_STATUS);
    assign w_wr_mask   = w_wr & (i_addr == ADDR_MASK);
    assign w_wr_rello  = w_wr & (i_addr == ADDR_RELLO);
    assign w_wr_relhi  = w_wr & (i_addr == ADDR_RELHI);
    assign w_clr       = w_wr_status & i_data[0];

`ifdef IRQ_SYNC_EN
    logic [1:0] r_uart_sync;
    logic [1:0] r_ch_sync;

    // Two-flop synchronisers for the asynchronous device interrupt lines
    always_ff @(posedge i_eclk or posedge i_reset) begin
        if (i_reset) begin
            r_uart_sync <= 2'b11;
            r_ch_sync   <= 2'b11;
        end else begin
            r_uart_sync <= {r_uart_sync[0], i_uartirq};
            r_ch_sync   <= {r_ch_sync[0], i_chirq};
        end
    end

    assign w_uart_n = r_uart_sync[1];
    assign w_ch_n   = r_ch_sync[1];
`else
    assign w_uart_n = i_uartirq;
    assign w_ch_n   = i_chirq;
`endif

    assign w_uart = ~w_uart_n;
    assign w_ch   = ~w_ch_n;

    // Prescaler/counter next state; a RELHI write overrides any tick on the same edge
    always_comb begin
        w_presc_next = r_presc;
        w_count_next = r_count;
        w_expire     = 1'b0;
        if (w_wr_relhi) begin
            w_presc_next = 16'h0000;
            w_count_next = {i_data, r_rel_lo_stage};
        end else if (r_reload == 16'h0000) begin
            w_presc_next = 16'h0000;
            w_count_next = 16'h0000;
        end else if (r_presc >= PS_LAST) begin
            w_presc_next = 16'h0000;
            // A counter of 0 with a live reload cannot arise normally; treat it as
            // an expiry so the timer always recovers to a defined period.
            if (r_count <= 16'h0001) begin
                w_count_next = r_reload;
                w_expire     = 1'b1;
            end else begin
                w_count_next = r_count - 16'h0001;
            end
        end else begin
            w_presc_next = r_presc + 16'h0001;
        end
    end

    // Pending/overrun flags: an expiry beats a same-edge clear and leaves TOVR alone
    always_comb begin
        w_tpend_next = r_tpend;
        w_tovr_next  = r_tovr;
        if (w_expire) begin
            w_tpend_next = 1'b1;
            if (w_clr) begin
                w_tovr_next = r_tovr;
            end else begin
                w_tovr_next = r_tovr | r_tpend;
            end
        end else if (w_clr) begin
            w_tpend_next = 1'b0;
            w_tovr_next  = 1'b0;
        end else begin
            w_tpend_next = r_tpend;
            w_tovr_next  = r_tovr;
        end
    end

    // Interrupt combine uses next-state flags so irq_n follows its cause by one edge
    always_comb begin
        if (w_wr_mask) begin
            w_mask_next = i_data[2:0];
        end else begin
            w_mask_next = r_mask;
        end
        w_irq_n_next = ~((w_tpend_next & w_mask_next[0]) |
                         (w_uart       & w_mask_next[1]) |
                         (w_ch         & w_mask_next[2]));
    end

    // Register file, timer and registered irq_n
    always_ff @(posedge i_eclk or posedge i_reset) begin
        if (i_reset) begin
            r_mask         <= 3'b000;
            r_reload       <= 16'h0000;
            r_rel_lo_stage <= 8'h00;
            r_count        <= 16'h0000;
            r_presc        <= 16'h0000;
            r_tpend        <= 1'b0;
            r_tovr         <= 1'b0;
            r_irq_n        <= 1'b1;
        end else begin
            r_mask  <= w_mask_next;
            r_count <= w_count_next;
            r_presc <= w_presc_next;
            r_tpend <= w_tpend_next;
            r_tovr  <= w_tovr_next;
            r_irq_n <= w_irq_n_next;
            if (w_wr_rello) begin
                r_rel_lo_stage <= i_data;
            end
            if (w_wr_relhi) begin
                r_reload <= {i_data, r_rel_lo_stage};
            end
        end
    end

    // Combinational read mux
    always_comb begin
        w_rd_data = 8'h00;
        case (i_addr)
            ADDR_STATUS: w_rd_data = {4'b0000, r_tovr, w_ch, w_uart, r_tpend};
            ADDR_MASK:   w_rd_data = {5'b00000, r_mask};
            ADDR_RELLO:  w_rd_data = r_reload[7:0];
            ADDR_RELHI:  w_rd_data = r_reload[15:8];
            default:     w_rd_data = 8'h00;
        endcase
    end

    assign o_data    = w_rd ? w_rd_data : 8'h00;
    assign o_data_oe = w_rd;
    assign irq_n     = r_irq_n;

endmodule
